// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD scan sequencer and its read pipe.
package sad_pkg;

  localparam int WIN_WORDS     = 4;
  localparam int FRAME_PRELOAD = 3;
  localparam int SAD_W         = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WIN,
    S_FRM,
    S_DRAIN,
    S_RD_MIN,
    S_RD_TAG,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RK_WIN,
    RK_PRE,
    RK_SCORE
  } read_kind_t;

endpackage

// File: rtl/sad_read_pipe.sv
// One-stage delay from read issue to data return; turns read kind into SAD-unit strobes and tag.
module sad_read_pipe
  import sad_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_valid,
  input  read_kind_t        i_kind,
  input  logic [ADDR_W-1:0] i_tag,
  output logic              o_window_shift,
  output logic              o_frame_shift,
  output logic              o_min_in,
  output logic [ADDR_W-1:0] o_tag
);

  logic              r_window_shift;
  logic              r_frame_shift;
  logic              r_min_in;
  logic [ADDR_W-1:0] r_tag;

  // Tag only moves on scoring reads so it holds between min_in pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_window_shift <= 1'b0;
      r_frame_shift  <= 1'b0;
      r_min_in       <= 1'b0;
      r_tag          <= '0;
    end else begin
      r_window_shift <= i_valid && (i_kind == RK_WIN);
      r_frame_shift  <= i_valid && (i_kind != RK_WIN);
      r_min_in       <= i_valid && (i_kind == RK_SCORE);
      if (i_valid && (i_kind == RK_SCORE)) r_tag <= i_tag;
    end
  end

  assign o_window_shift = r_window_shift;
  assign o_frame_shift  = r_frame_shift;
  assign o_min_in       = r_min_in;
  assign o_tag          = r_tag;

endmodule

// File: rtl/sad_scan_sequencer.sv
// Sequences window load, frame scan and min/tag readback for the SAD unit, one read per cycle.
module sad_scan_sequencer
  import sad_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int POS_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] win_base,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [POS_W-1:0]  num_pos,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              frame_shift,
  output logic              window_shift,
  output logic              min_in,
  output logic              load_min,
  output logic              min_clear,
  output logic [ADDR_W-1:0] tag,
  input  logic [31:0]       SAD_value,
  output logic              busy,
  output logic              done,
  output logic [SAD_W-1:0]  best_sad,
  output logic [ADDR_W-1:0] best_tag,
  output logic              best_valid
);

  localparam int CNT_W = POS_W + 2;
  localparam logic [CNT_W-1:0] C_WIN_LAST = CNT_W'(WIN_WORDS - 1);
  localparam logic [CNT_W-1:0] C_PRELOAD  = CNT_W'(FRAME_PRELOAD);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_next_cnt, w_frm_last;
  logic [ADDR_W-1:0] r_win_base, r_frame_base;
  logic [POS_W-1:0]  r_num_pos;
  logic              r_mem_rd, r_min_clear, r_done, r_best_valid;
  logic [ADDR_W-1:0] r_mem_addr, r_best_tag;
  read_kind_t        r_issue_kind, w_issue_kind;
  logic [SAD_W-1:0]  r_best_sad;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr, w_issue_tag;

  assign w_frm_last = CNT_W'(r_num_pos) + CNT_W'(FRAME_PRELOAD - 1);

  always_comb begin
    w_next     = r_state;
    w_next_cnt = '0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CLR;
      S_CLR:    w_next = S_WIN;
      S_WIN:    if (r_cnt == C_WIN_LAST) w_next = S_FRM;
                else w_next_cnt = r_cnt + 1'b1;
      S_FRM:    if (r_cnt == w_frm_last) w_next = S_DRAIN;
                else w_next_cnt = r_cnt + 1'b1;
      S_DRAIN:  w_next = S_RD_MIN;
      S_RD_MIN: w_next = S_RD_TAG;
      S_RD_TAG: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Issue signals are decoded from the upcoming state so mem_rd can be a plain register.
  always_comb begin
    w_issue      = (w_next == S_WIN) || (w_next == S_FRM);
    w_issue_kind = RK_PRE;
    if (w_next == S_WIN)             w_issue_kind = RK_WIN;
    else if (w_next_cnt >= C_PRELOAD) w_issue_kind = RK_SCORE;
    w_issue_addr = ((w_next == S_WIN) ? r_win_base : r_frame_base)
                   + ADDR_W'({w_next_cnt, 2'b00});
  end

  assign w_issue_tag = r_mem_addr - ADDR_W'(4 * FRAME_PRELOAD);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_win_base   <= '0;
      r_frame_base <= '0;
      r_num_pos    <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_issue_kind <= RK_WIN;
      r_min_clear  <= 1'b0;
      r_done       <= 1'b0;
      r_best_valid <= 1'b0;
      r_best_sad   <= '0;
      r_best_tag   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_next_cnt;
      if ((r_state == S_IDLE) && start) begin
        r_win_base   <= win_base;
        r_frame_base <= frame_base;
        r_num_pos    <= num_pos;
      end
      r_mem_rd <= w_issue;
      if (w_issue) begin
        r_mem_addr   <= w_issue_addr;
        r_issue_kind <= w_issue_kind;
      end
      r_min_clear <= (w_next == S_CLR);
      r_done      <= (w_next == S_DONE);
      if (w_next == S_DONE)     r_best_valid <= (r_num_pos != '0);
      if (r_state == S_RD_MIN)  r_best_sad   <= SAD_value[SAD_W-1:0];
      if (r_state == S_RD_TAG)  r_best_tag   <= ADDR_W'(SAD_value);
    end
  end

  sad_read_pipe #(.ADDR_W(ADDR_W)) u_pipe (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_valid        (r_mem_rd),
    .i_kind         (r_issue_kind),
    .i_tag          (w_issue_tag),
    .o_window_shift (window_shift),
    .o_frame_shift  (frame_shift),
    .o_min_in       (min_in),
    .o_tag          (tag)
  );

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign min_clear  = r_min_clear;
  assign done       = r_done;
  assign best_valid = r_best_valid;
  assign best_sad   = r_best_sad;
  assign best_tag   = r_best_tag;
  assign load_min   = (r_state == S_RD_MIN);
  assign busy       = (r_state != S_IDLE);

endmodule
